// File: rtl/enemy_spawner.sv
// Enemy spawn scheduler: turns the random stream into timed spawn offers for the
// lowest free enemy slot, with a randomised frame gap between accepted spawns.
module enemy_spawner #(
  parameter int unsigned X_MAX    = 550,
  parameter int unsigned SLOTS    = 8,
  parameter int unsigned SLOT_W   = 3,
  parameter int unsigned MIN_GAP  = 16,
  parameter int unsigned GAP_MASK = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              game_en,
  input  logic              frame_tick,
  input  logic [11:0]       rand_in,
  input  logic [SLOTS-1:0]  slot_free,
  output logic              spawn_valid,
  input  logic              spawn_ready,
  output logic [11:0]       spawn_x,
  output logic [SLOT_W-1:0] spawn_slot,
  output logic [15:0]       spawn_cnt,
  output logic              busy
);

  localparam logic [11:0] XMax    = 12'(X_MAX);
  localparam logic [8:0]  MinGap  = 9'(MIN_GAP);
  localparam logic [11:0] GapMask = 12'(GAP_MASK);

  typedef enum logic [1:0] {StIdle, StWait, StPick, StOffer} state_e;

  state_e            state_q, state_d;
  logic [8:0]        gap_q, gap_d;
  logic [11:0]       x_q, x_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              x_held_q, x_held_d;

  logic [11:0]       x_sub, x_fold;
  logic [SLOT_W-1:0] slot_pick;

  // Single subtraction fold; anything still out of range collapses to 0.
  always_comb begin
    x_sub = rand_in - XMax;
    if (rand_in < XMax) begin
      x_fold = rand_in;
    end else if (x_sub < XMax) begin
      x_fold = x_sub;
    end else begin
      x_fold = '0;
    end
  end

  // Descending scan so the lowest free index is the last to win.
  always_comb begin
    slot_pick = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (slot_free[i]) slot_pick = SLOT_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    x_d      = x_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    x_held_d = x_held_q;
    if (!game_en) begin
      state_d  = StIdle;
      gap_d    = '0;
      x_held_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWait;
          gap_d   = MinGap;
        end
        StWait: begin
          if (frame_tick) begin
            if (gap_q <= 9'd1) begin
              state_d = StPick;
              gap_d   = '0;
            end else begin
              gap_d = gap_q - 9'd1;
            end
          end
        end
        StPick: begin
          // X is captured once; later cycles waiting for a free slot keep it.
          if (!x_held_q) begin
            x_d      = x_fold;
            x_held_d = 1'b1;
          end
          if (|slot_free) begin
            slot_d   = slot_pick;
            state_d  = StOffer;
            x_held_d = 1'b0;
          end
        end
        StOffer: begin
          if (spawn_ready) begin
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            gap_d   = MinGap + 9'(rand_in & GapMask);
            state_d = StWait;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      gap_q    <= '0;
      x_q      <= '0;
      slot_q   <= '0;
      cnt_q    <= '0;
      x_held_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      x_q      <= x_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      x_held_q <= x_held_d;
    end
  end

  assign spawn_valid = (state_q == StOffer);
  assign busy        = (state_q != StIdle);
  assign spawn_x     = x_q;
  assign spawn_slot  = slot_q;
  assign spawn_cnt   = cnt_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Bench for enemy_spawner: directed scenarios plus random traffic, checked by a
// scoreboard fed from a spawn-rule reference model.
module tb_enemy_spawner;

  localparam int XMax   = 550;
  localparam int MinGap = 16;

  logic        clk = 1'b0;
  logic        rst_n, game_en, frame_tick, spawn_ready, spawn_valid, busy;
  logic [11:0] rand_in, spawn_x;
  logic [7:0]  slot_free;
  logic [2:0]  spawn_slot;
  logic [15:0] spawn_cnt;

  enemy_spawner #(
    .X_MAX   (550),
    .SLOTS   (8),
    .SLOT_W  (3),
    .MIN_GAP (16),
    .GAP_MASK(15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_en    (game_en),
    .frame_tick (frame_tick),
    .rand_in    (rand_in),
    .slot_free  (slot_free),
    .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready),
    .spawn_x    (spawn_x),
    .spawn_slot (spawn_slot),
    .spawn_cnt  (spawn_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: spawn rules in terms of frames left, pick pending, offer pending.
  bit m_run, m_pick, m_offer, m_x_taken;
  int m_left, m_x, m_cnt;
  int exp_x[$];
  int exp_slot[$];

  function automatic int fold_ref(input int r);
    if (r < XMax) return r;
    if (r - XMax < XMax) return r - XMax;
    return 0;
  endfunction

  function automatic int lowest_free(input logic [7:0] f);
    for (int i = 0; i < 8; i++) begin
      if (f[i]) return i;
    end
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        m_run = 0; m_pick = 0; m_offer = 0; m_x_taken = 0;
        m_left = 0; m_x = 0; m_cnt = 0;
        exp_x.delete();
        exp_slot.delete();
      end else if (!game_en) begin
        m_run = 0; m_pick = 0; m_offer = 0; m_x_taken = 0; m_left = 0;
      end else if (!m_run) begin
        m_run  = 1;
        m_left = MinGap;
      end else if (m_offer) begin
        if (spawn_ready) begin
          m_offer = 0;
          if (m_cnt < 65535) m_cnt++;
          m_left = MinGap + (int'(rand_in) % 16);
        end
      end else if (m_pick) begin
        if (!m_x_taken) begin
          m_x       = fold_ref(int'(rand_in));
          m_x_taken = 1;
        end
        if (slot_free != 8'd0) begin
          m_pick    = 0;
          m_offer   = 1;
          m_x_taken = 0;
          exp_x.push_back(m_x);
          exp_slot.push_back(lowest_free(slot_free));
        end
      end else if (frame_tick) begin
        if (m_left <= 1) begin
          m_left = 0;
          m_pick = 1;
        end else begin
          m_left--;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  bit mon_prev_valid;
  int mon_x, mon_slot;

  initial begin
    mon_prev_valid = 0;
    mon_x = 0;
    mon_slot = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("spawn_valid", int'(spawn_valid), int'(m_offer));
        check("busy", int'(busy), int'(m_run));
        check("spawn_cnt", int'(spawn_cnt), m_cnt);
        if (spawn_valid && !mon_prev_valid) begin
          check("pending_spawns", exp_x.size(), 1);
          if (exp_x.size() > 0) begin
            mon_x    = exp_x.pop_front();
            mon_slot = exp_slot.pop_front();
          end
        end
        if (spawn_valid) begin
          check("spawn_x", int'(spawn_x), mon_x);
          check("spawn_slot", int'(spawn_slot), mon_slot);
        end
      end
      mon_prev_valid = spawn_valid;
    end
  end

  // Driver helpers
  int cyc, tick_period, tick_cnt;
  bit rand_mode;

  task automatic step();
    @(negedge clk);
    cyc++;
    frame_tick = (tick_period != 0 && cyc % tick_period == 0);
    if (frame_tick) tick_cnt++;
    if (rand_mode) rand_in = 12'($urandom_range(0, 4095));
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (spawn_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check({name, "_valid_seen"}, int'(spawn_valid === 1'b1), 1);
  endtask

  initial begin
    rst_n = 1'b0; game_en = 1'b0; frame_tick = 1'b0; spawn_ready = 1'b0;
    rand_in = 12'd0; slot_free = 8'd0;
    cyc = 0; tick_period = 0; tick_cnt = 0; rand_mode = 0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(spawn_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_x", int'(spawn_x), 0);
    check("rst_slot", int'(spawn_slot), 0);
    check("rst_cnt", int'(spawn_cnt), 0);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_busy", int'(busy), 0);

    // First spawn after MIN_GAP ticks, ticks every 10 cycles.
    game_en = 1'b1; slot_free = 8'hFF; rand_in = 12'd100; spawn_ready = 1'b1;
    frame_tick = 1'b0; tick_cnt = 0; cyc = 0; tick_period = 10;
    wait_valid(400, "first");
    check("first_ticks", tick_cnt, 16);
    check("first_x", int'(spawn_x), 100);
    check("first_slot", int'(spawn_slot), 0);
    step();
    check("first_cnt", int'(spawn_cnt), 1);

    // Fold of out-of-range X values.
    rand_in = 12'd700; tick_period = 1;
    wait_valid(100, "fold700");
    check("fold700_x", int'(spawn_x), 150);
    rand_in = 12'd4095;
    step();
    wait_valid(100, "fold4095");
    check("fold4095_x", int'(spawn_x), 0);

    // No free slot: hold in pick, X frozen from first sample.
    slot_free = 8'h00; rand_mode = 1;
    step();
    repeat (40) step();
    check("nofree_valid", int'(spawn_valid), 0);
    check("nofree_busy", int'(busy), 1);
    slot_free = 8'b0010_0100;
    wait_valid(5, "slot2");
    check("slot2_slot", int'(spawn_slot), 2);

    // Back-pressure with changing rand, then accept with rand[3:0]=7.
    spawn_ready = 1'b0;
    repeat (5) step();
    rand_mode = 0; rand_in = 12'h3A7; spawn_ready = 1'b1;
    frame_tick = 1'b0; tick_cnt = 0; cyc = 0; tick_period = 3;
    step();
    wait_valid(200, "gap23");
    check("gap23_ticks", tick_cnt, 23);
    check("gap23_x", int'(spawn_x), 385);

    // Abort by game_en during offer, then restart at MIN_GAP.
    spawn_ready = 1'b0; game_en = 1'b0;
    step();
    check("abort_valid", int'(spawn_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_cnt", int'(spawn_cnt), 4);
    game_en = 1'b1; spawn_ready = 1'b1;
    frame_tick = 1'b0; tick_cnt = 0; cyc = 0; tick_period = 3;
    wait_valid(200, "restart");
    check("restart_ticks", tick_cnt, 16);
    step();

    // Saturation of the accept counter.
    spawn_ready = 1'b0;
    @(posedge clk);
    #2;
    force dut.cnt_q = 16'hFFFE;
    m_cnt = 65534;
    @(posedge clk);
    #2;
    release dut.cnt_q;
    spawn_ready = 1'b1; tick_period = 1;
    wait_valid(100, "sat1");
    step();
    check("sat1_cnt", int'(spawn_cnt), 65535);
    wait_valid(100, "sat2");
    step();
    check("sat2_cnt", int'(spawn_cnt), 65535);

    // Asynchronous reset while offering.
    spawn_ready = 1'b0;
    wait_valid(100, "rstoffer");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(spawn_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_cnt", int'(spawn_cnt), 0);
    check("arst_x", int'(spawn_x), 0);
    step();
    rst_n = 1'b1;

    // Random traffic against the model.
    rand_mode = 1; tick_period = 0;
    for (int i = 0; i < 2500; i++) begin
      step();
      frame_tick  = 1'($urandom_range(0, 1));
      slot_free   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
      spawn_ready = 1'($urandom_range(0, 1));
      game_en     = ($urandom_range(0, 199) != 0);
    end
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
